// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter sequencer: boot, sequential fetch, and one-cycle
// flush on jump/branch redirects, with sticky misalignment flag and redirect counter.
module pc_fetch_ctrl #(
   parameter int unsigned           WIDTH     = 32,
   parameter logic [WIDTH-1:0]      RESET_VEC = '0,
   parameter int unsigned           STEP      = 4
) (
   input  logic             clka,
   input  logic             rsta,
   input  logic             stall,
   input  logic             imem_ready,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp_valid,
   input  logic [WIDTH-1:0] jmp_target,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic             flush,
   output logic             misalign,
   output logic [15:0]      redirect_cnt
);

   // state       | meaning
   // ST_BOOT     | first cycle after reset, pc=RESET_VEC, no fetch issued
   // ST_FETCH    | pc is a live fetch request, advances or holds
   // ST_REDIRECT | pc was just reloaded from a target, flush bubble
   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             pc_valid_q, pc_valid_d;
   logic             flush_q, flush_d;
   logic             misalign_q, misalign_d;
   logic [15:0]      redirect_cnt_q, redirect_cnt_d;

   logic             redir_req;
   logic [WIDTH-1:0] redir_tgt;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_VEC;
         pc_valid_q     <= 1'b0;
         flush_q        <= 1'b0;
         misalign_q     <= 1'b0;
         redirect_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pc_valid_q     <= pc_valid_d;
         flush_q        <= flush_d;
         misalign_q     <= misalign_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   // Jump outranks branch when both arrive in the same cycle.
   assign redir_req = jmp_valid | br_taken;
   assign redir_tgt = jmp_valid ? jmp_target : br_target;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      misalign_d     = misalign_q;
      redirect_cnt_d = redirect_cnt_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH, ST_REDIRECT: begin
            if (redir_req) begin
               state_d    = ST_REDIRECT;
               pc_d       = redir_tgt & ALIGN_MASK;
               misalign_d = misalign_q | (|redir_tgt[1:0]);
               if (redirect_cnt_q != 16'hFFFF) begin
                  redirect_cnt_d = redirect_cnt_q + 16'd1;
               end
            end else if (state_q == ST_REDIRECT) begin
               state_d = ST_FETCH;
            end else if (!stall && imem_ready) begin
               pc_d = pc_q + STEP_W;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      pc_valid_d = (state_d == ST_FETCH);
      flush_d    = (state_d == ST_REDIRECT);
   end

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign flush        = flush_q;
   assign misalign     = misalign_q;
   assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_ctrl;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic        stall = 1'b0;
   logic        imem_ready = 1'b1;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        jmp_valid = 1'b0;
   logic [31:0] jmp_target = '0;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush;
   logic        misalign;
   logic [15:0] redirect_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pc_fetch_ctrl #(.WIDTH(32), .RESET_VEC(32'h0000_0000), .STEP(4)) dut (
      .clka(clka), .rsta(rsta), .stall(stall), .imem_ready(imem_ready),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .pc(pc), .pc_valid(pc_valid), .flush(flush),
      .misalign(misalign), .redirect_cnt(redirect_cnt)
   );

   always #5 clka = ~clka;

   // Behavioural model: tracks what the fetch unit must present after each edge.
   logic [31:0] m_pc;
   logic        m_valid, m_flush, m_mis, m_boot;
   logic [15:0] m_cnt;

   always @(posedge clka or posedge rsta) begin
      if (rsta) begin
         m_pc = 32'h0; m_valid = 0; m_flush = 0; m_mis = 0; m_cnt = 0; m_boot = 1;
      end else if (m_boot) begin
         m_boot = 0; m_valid = 1;
      end else if (jmp_valid || br_taken) begin
         logic [31:0] t;
         t = jmp_valid ? jmp_target : br_target;
         m_pc = {t[31:2], 2'b00};
         if (t[1:0] != 2'b00) m_mis = 1;
         if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
         m_flush = 1; m_valid = 0;
      end else if (m_flush) begin
         m_flush = 0; m_valid = 1;
      end else if (!stall && imem_ready) begin
         m_pc = m_pc + 32'd4;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clka) begin
      check("pc", pc, m_pc);
      check("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
      check("flush", {31'd0, flush}, {31'd0, m_flush});
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, m_cnt});
   end

   task automatic drive(input logic j, input logic [31:0] jt, input logic b,
                        input logic [31:0] bt, input logic st, input logic rdy);
      @(negedge clka); #1;
      jmp_valid = j; jmp_target = jt; br_taken = b; br_target = bt;
      stall = st; imem_ready = rdy;
   endtask

   task automatic edge_then_sample();
      @(posedge clka); #1;
   endtask

   initial begin
      repeat (2) @(posedge clka);
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, pc_valid}, 32'd0);

      // 1. boot then sequential fetch
      drive(0, 0, 0, 0, 0, 1); rsta = 0;
      check("boot_valid", {31'd0, pc_valid}, 32'd0);
      edge_then_sample(); check("first_pc", pc, 32'h0);
      check("first_valid", {31'd0, pc_valid}, 32'd1);
      edge_then_sample(); check("seq_pc4", pc, 32'h4);
      edge_then_sample(); check("seq_pc8", pc, 32'h8);

      // 2. stall holds pc
      drive(0, 0, 0, 0, 1, 1);
      repeat (3) begin edge_then_sample(); check("stall_hold", pc, 32'h8); end
      drive(0, 0, 0, 0, 0, 1);
      edge_then_sample(); check("stall_release", pc, 32'hC);

      // 3. taken branch
      drive(0, 0, 1, 32'h40, 0, 1);
      edge_then_sample(); check("br_pc", pc, 32'h40);
      check("br_flush", {31'd0, flush}, 32'd1);
      check("br_cnt", {16'd0, redirect_cnt}, 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      edge_then_sample(); check("br_noflush", {31'd0, flush}, 32'd0);
      check("br_pc_hold", pc, 32'h40);
      edge_then_sample(); check("br_next", pc, 32'h44);

      // 4. jump beats branch, also beats stall
      drive(1, 32'h100, 1, 32'h200, 1, 0);
      edge_then_sample(); check("jmp_prio", pc, 32'h100);
      drive(0, 0, 0, 0, 0, 1);
      edge_then_sample();

      // 5. misaligned jump target
      drive(1, 32'h103, 0, 0, 0, 1);
      edge_then_sample(); check("mis_pc", pc, 32'h100);
      check("mis_flag", {31'd0, misalign}, 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      repeat (3) edge_then_sample();
      check("mis_sticky", {31'd0, misalign}, 32'd1);

      // 6. wrap at top of address space, then reset mid-REDIRECT
      drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      edge_then_sample(); check("wrap_top", pc, 32'hFFFF_FFFC);
      edge_then_sample(); check("wrap_zero", pc, 32'h0);
      drive(0, 0, 1, 32'h20, 0, 1);
      edge_then_sample(); check("pre_rst_flush", {31'd0, flush}, 32'd1);
      #2 rsta = 1; #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_flush", {31'd0, flush}, 32'd0);
      check("async_rst_cnt", {16'd0, redirect_cnt}, 32'd0);

      // Redirect requests during BOOT are ignored.
      drive(1, 32'h80, 0, 0, 0, 1); rsta = 0;
      edge_then_sample(); check("boot_ignores_jmp", pc, 32'h0);

      // Randomized traffic with occasional async reset pulses.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 9) == 0), $urandom(),
               ($urandom_range(0, 6) == 0), $urandom(),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
         if ($urandom_range(0, 199) == 0) begin
            @(posedge clka); #3 rsta = 1;
            #1 check("rand_rst_pc", pc, 32'h0);
            @(negedge clka); #1 rsta = 0;
         end
      end

      @(negedge clka); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
